// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side framer.
// Holds default widths, the data type and the output buffer states.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 9;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ordered skid buffer between the FIFO read port and the stream.
// The state encoding doubles as the occupancy count.
module stream_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    import fifo_pkg::*;

    buf_state_e   state;
    logic [W-1:0] tail;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (wr) begin
                        head  <= wr_data;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (wr && pop) begin
                        head <= wr_data;
                    end else if (wr) begin
                        tail  <= wr_data;
                        state <= S_TWO;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // A write here is only legal alongside a pop
                    if (pop) begin
                        head <= tail;
                        if (wr) tail <= wr_data;
                        else    state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign occ = state;

endmodule

// File: rtl/fifo_rd_framer.sv
// FIFO read-side framer: pops the FIFO under a credit limit, buffers the
// registered read data and emits it as a valid/ready stream in packets.
module fifo_rd_framer #(
    parameter int DATA_W    = fifo_pkg::DATA_W,
    parameter int PKT_LEN   = 16,
    parameter int CNT_W     = fifo_pkg::CNT_W,
    parameter int PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [DATA_W-1:0]    fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    output logic [PKT_CNT_W-1:0] pkt_cnt,
    output logic                 busy
);

    import fifo_pkg::*;

    logic             inflight;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       credit;
    logic [CNT_W-1:0] beat_cnt;

    assign pop = m_valid & m_ready;

    // Slots committed after this edge; pop frees one, so m_ready feeds rd_en
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = arst_n & en & ~fifo_empty & (credit < 3'd2);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) inflight <= 1'b0;
        else         inflight <= fifo_rd_en;
    end

    stream_buf2 #(
        .W(DATA_W)
    ) u_buf (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr      (inflight),
        .wr_data (fifo_dout),
        .pop     (pop),
        .occ     (occ),
        .head    (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign m_last  = m_valid & (beat_cnt == CNT_W'(PKT_LEN - 1));
    assign busy    = inflight | m_valid;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            if (m_last) begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    ap_no_overflow: assert property (
        @(posedge clk) disable iff (!arst_n)
        !(inflight && occ == 2'd2 && !pop)
    );

    ap_no_underflow: assert property (
        @(posedge clk) disable iff (!arst_n)
        !(fifo_rd_en && fifo_empty)
    );

    ap_hold: assert property (
        @(posedge clk) disable iff (!arst_n)
        (m_valid && !m_ready) |=>
            (m_valid && $stable(m_data) && $stable(m_last))
    );

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Scoreboard bench for fifo_rd_framer with a behavioural FIFO read port.
// Driver loads the FIFO and queues expected beats; a monitor checks them.
module tb_fifo_rd_framer;

    localparam int DW = 8;
    localparam int PL = 16;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          en = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   pkt_cnt;
    logic          busy;

    logic          model_on = 1'b0;
    logic          man_empty = 1'b1;
    logic [DW-1:0] man_dout = '0;
    logic          model_empty = 1'b1;
    logic [DW-1:0] model_dout = '0;

    assign fifo_empty = model_on ? model_empty : man_empty;
    assign fifo_dout  = model_on ? model_dout  : man_dout;

    always #5 clk = ~clk;

    fifo_rd_framer #(
        .DATA_W(DW), .PKT_LEN(PL), .CNT_W(9), .PKT_CNT_W(16)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_cnt    (pkt_cnt),
        .busy       (busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic [DW-1:0] fq[$];
    exp_t          exp_q[$];

    int checks = 0;
    int errors = 0;
    int push_idx = 0;
    int rst_gen = 0;
    int rd_total = 0;
    int xfer_total = 0;
    int pkt_exp = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic load(int n, int base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(DW'(base + i));
            exp_q.push_back('{d: DW'(base + i), l: ((push_idx % PL) == PL - 1)});
            push_idx++;
        end
    endtask

    task automatic drain(int maxc);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) chk("drain_timeout", c, 0);
        repeat (2) @(negedge clk);
    endtask

    // FIFO read port: one-cycle registered read, registered empty flag
    initial begin : fifo_model
        logic rd_s;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd_en & arst_n;
            @(posedge clk);
            if (rd_s && fq.size() > 0) model_dout <= fq.pop_front();
            model_empty <= (fq.size() == 0);
        end
    end

    initial begin : monitor
        int   gen;
        logic pv;
        logic [DW-1:0] pd;
        logic pl;
        int   pend;
        exp_t e;
        gen = 0;
        pv = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (gen != rst_gen) begin
                gen = rst_gen;
                pv = 1'b0;
                rd_total = 0;
                xfer_total = 0;
                pkt_exp = 0;
            end
            if (arst_n) begin
                pend = rd_total - xfer_total;
                if (fifo_rd_en) chk("rd_while_empty", fifo_empty, 0);
                if (fifo_rd_en && !(m_valid && m_ready))
                    chk("credit", pend < 2, 1);
                if (pv) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, pd);
                    chk("stall_last", m_last, pl);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", m_data, e.d);
                        chk("last", m_last, e.l);
                        if (e.l) pkt_exp++;
                    end
                    xfer_total++;
                end
                if (fifo_rd_en) rd_total++;
                pv = m_valid && !m_ready;
                pd = m_data;
                pl = m_last;
            end
        end
    end

    initial begin : driver
        int lat;
        int rds;
        int n;
        int c;

        // Reset holds everything at zero whatever the inputs do
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            en        = 1'($urandom_range(0, 1));
            m_ready   = 1'($urandom_range(0, 1));
            man_empty = 1'($urandom_range(0, 1));
            man_dout  = DW'($urandom);
            @(negedge clk);
            chk("reset_outs",
                {fifo_rd_en, m_valid, m_data, m_last, pkt_cnt, busy}, 0);
        end

        // Streaming: 32 beats, two packets, no bubbles
        load(32, 8'h00);
        model_on = 1'b1;
        en = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("rd_en_first", fifo_rd_en, 1);
        lat = 0;
        while (!m_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk("no_bubble", m_valid, 1);
        end
        drain(50);
        chk("pkt_cnt_stream", pkt_cnt, 2);
        chk("busy_idle", busy, 0);

        // Back-pressure: random ready over 64 beats
        load(64, 8'h40);
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < 2000) begin
            @(posedge clk);
            #1;
            m_ready = 1'($urandom_range(0, 1));
            c++;
        end
        if (c >= 2000) chk("bp_timeout", c, 0);
        m_ready = 1'b1;
        drain(20);
        chk("pkt_cnt_bp", pkt_cnt, 6);

        // Underflow guard: exactly three pops for three beats
        load(3, 8'hC0);
        rds = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rds++;
        end
        chk("rd_count_3", rds, 3);
        chk("pkt_cnt_3", pkt_cnt, 6);

        // en toggle after 5 transfers; beat count carries across the pause
        load(20, 8'hD0);
        n = 0;
        c = 0;
        while (n < 5 && c < 100) begin
            @(negedge clk);
            if (m_valid && m_ready) n++;
            c++;
        end
        if (c >= 100) chk("en_wait_timeout", c, 0);
        @(posedge clk);
        #1;
        en = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rd_en_off", fifo_rd_en, 0);
        end
        chk("held_max2", (exp_q.size() - fq.size()) <= 2, 1);
        chk("held_valid", m_valid, 1);
        @(posedge clk);
        #1;
        en = 1'b1;
        m_ready = 1'b1;
        drain(100);
        chk("pkt_cnt_en", pkt_cnt, 7);

        // Async reset mid-packet: beat counter sits at 7 here
        load(20, 8'h20);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!m_valid && c < 20);
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        chk("async_clear",
            {fifo_rd_en, m_valid, m_data, m_last, pkt_cnt, busy}, 0);
        fq.delete();
        exp_q.delete();
        push_idx = 0;
        rst_gen++;
        load(20, 8'hA0);
        arst_n = 1'b1;
        drain(100);
        chk("pkt_cnt_after_rst", pkt_cnt, 1);
        chk("pkt_model_after_rst", pkt_cnt, pkt_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_framer.md
Name: fifo_rd_framer

Overview:
- Downstream consumer of the synchronous FIFO. Drives the FIFO's read enable and absorbs its one-cycle registered read latency. Presents the data as a valid/ready stream with back-pressure.
- Groups the outgoing beats into fixed-length packets: asserts m_last on every PKT_LEN-th beat and counts the completed packets.
- Sits between the FIFO read port and any stream sink (UART tx, DMA writer). It is the only agent allowed to pop the FIFO.

Parameters:
- DATA_W, 8, width of FIFO data and of m_data.
- PKT_LEN, 16, beats per packet. Legal range 1..2**CNT_W-1.
- CNT_W, 9, width of the beat counter. Matches the FIFO address width.
- PKT_CNT_W, 16, width of pkt_cnt.

Ports:
- clk  in  1  rising-edge clock, shared with the FIFO.
- arst_n  in  1  asynchronous active-low reset. Assert asynchronously; deassert synchronously to clk.
- en  in  1  read enable. When low, no new FIFO reads are issued.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_W  FIFO read data. Valid in the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop request.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_W  stream data.
- m_last  out  1  marks the last beat of a packet.
- pkt_cnt  out  PKT_CNT_W  number of completed packets. Wraps.
- busy  out  1  high while a read is in flight or buffered data is present.

Behaviour:
- Reset (arst_n low): immediately clears all state. The following all go to 0: fifo_rd_en, m_valid, m_data, m_last, pkt_cnt, busy, beat_cnt, inflight, and buffer occupancy.
- Reset mid-operation: an in-flight read and any buffered beats are discarded, with no recovery. The FIFO is reset by the same system event.
- Handshake: a beat transfers on a cycle where m_valid and m_ready are both high.
  - While m_valid is high and m_ready is low, m_data and m_last hold stable.
  - m_valid never drops without a transfer.
- Read latency: inflight is fifo_rd_en registered. When inflight is 1, fifo_dout is written into the 2-entry buffer in that cycle.
- Buffer FSM, state = occupancy:
  - S_EMPTY -> S_ONE on write.
  - S_ONE -> S_TWO on write without pop.
  - S_ONE -> S_EMPTY on pop without write.
  - S_TWO -> S_ONE on pop.
  - Write and pop in the same cycle: occupancy is unchanged, order is preserved, head advances.
  - Write in S_TWO without pop is impossible by the credit rule. An assertion must flag it.
- Credit rule: fifo_rd_en = en & ~fifo_empty & (occ + inflight - pop < 2), where pop = m_valid & m_ready.
  - fifo_rd_en therefore has a combinational path from m_ready. This is accepted and documented.
  - Never asserted while fifo_empty is high. The FIFO has no underflow protection.
- Throughput: with m_ready held high and the FIFO non-empty, one beat per cycle after a 2-cycle initial latency (rd_en -> buffer write -> m_valid).
- m_valid = (occ != 0). m_data = buffer head.
- m_last = m_valid & (beat_cnt == PKT_LEN-1).
- beat_cnt increments on pop. On a pop with m_last it wraps to 0 and pkt_cnt increments, modulo 2**PKT_CNT_W.
- PKT_LEN = 1: m_last is high on every beat.
- en low: in-flight read completes into the buffer. Buffered beats still drain. beat_cnt is preserved across en toggles.
- busy = inflight | (occ != 0).

Decomposition:
- Package fifo_pkg holds:
  - default DATA_W and CNT_W constants, shared with the FIFO;
  - typedef data_t (logic [DATA_W-1:0]);
  - enum buf_state_e {S_EMPTY, S_ONE, S_TWO}.
- Sub-module stream_buf2: 2-entry ordered buffer with write port, pop, occupancy and head data, containing the FSM.
- Top level holds the credit logic, inflight flag, beat/packet counters and assertions.

Test Plan:
- Reset: hold arst_n low while toggling every input -> all outputs 0. Release, then fifo_empty=0, en=1 -> fifo_rd_en=1 on the first cycle.
- Streaming: preload FIFO with 0x00..0x1F, PKT_LEN=16, m_ready=1.
  - m_data runs 0x00..0x1F, one beat per cycle, with no bubbles after the first.
  - m_last on 0x0F and 0x1F. pkt_cnt ends at 2.
- Back-pressure: m_ready random 50%, 64 beats preloaded.
  - Data is in order with none lost or duplicated.
  - m_data stays stable during stalls.
  - fifo_rd_en is never asserted while occ + inflight = 2 and no pop occurs.
- Underflow guard: FIFO holds 3 beats and is then drained -> fifo_rd_en is asserted exactly 3 times and never while fifo_empty=1.
- en toggle: drop en after 5 beats have been read, with m_ready=0.
  - fifo_rd_en stops. At most 2 beats are buffered.
  - Re-raise en -> the stream continues with beat_cnt intact and m_last on the 16th beat overall.
- Async reset mid-packet: assert arst_n low for 1 ns mid-cycle during beat 7 -> outputs clear without waiting for a clock edge. pkt_cnt=0, and the next m_last comes 16 beats after reset.
